// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scan controller for an 8-digit multiplexed seven-segment display.
// Steps the digit select CIn through the enabled digits of dig_mask, one slot of
// DIV cycles per digit. The first BLANK cycles of every slot are blanked, which
// suppresses ghosting while the upstream mux settles on the new digit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; low blanks the outputs and restarts the scan
//   dig_mask    : per-digit display enable, sampled only on slot-start edges
//   seg_in      : segment pattern from the upstream mux (combinational from CIn)
//   CIn         : registered digit select to the upstream mux
//   seg_out     : active-high segment drive
//   an_n        : active-low one-hot digit anodes
//   frame_done  : one-cycle pulse on the first cycle of each scan wrap
module seg7_scan_ctrl #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] dig_mask,
  input  logic [6:0] seg_in,
  output logic [2:0] CIn,
  output logic [6:0] seg_out,
  output logic [7:0] an_n,
  output logic       frame_done
);

  localparam int unsigned CW = 16;

  logic [CW-1:0] r_cnt;
  logic          r_restart;  // first enabled edge begins a slot at once
  logic          r_first;    // next successful search starts at digit 0
  logic          r_active;   // current slot has a digit selected

  logic          w_slot_start;
  logic [2:0]    w_base;
  logic [2:0]    w_idx;
  logic [2:0]    w_pick;
  logic          w_found;
  logic          w_wrap;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_cin_nxt;
  logic          w_act_nxt;
  logic          w_show;

  // Next-digit search and next-state values for the coming edge.
  always_comb begin
    w_slot_start = r_restart || (r_cnt == CW'(DIV - 1));
    w_base       = r_first ? 3'd0 : CIn + 3'd1;
    w_idx        = w_base;
    w_pick       = w_base;
    w_found      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_idx = w_base + 3'(i);
      if (!w_found && dig_mask[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
    w_wrap    = r_first || (w_pick <= CIn);
    w_cnt_nxt = w_slot_start ? '0 : r_cnt + CW'(1);
    w_cin_nxt = (w_slot_start && w_found) ? w_pick : CIn;
    w_act_nxt = w_slot_start ? w_found : r_active;
    // Slot position >= BLANK >= 1 guarantees seg_in was sampled with the new CIn.
    w_show    = w_act_nxt && (w_cnt_nxt >= CW'(BLANK));
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_restart  <= 1'b1;
      r_first    <= 1'b1;
      r_active   <= 1'b0;
      CIn        <= 3'd0;
      seg_out    <= 7'h00;
      an_n       <= 8'hFF;
      frame_done <= 1'b0;
    end else if (!en) begin
      r_cnt      <= '0;
      r_restart  <= 1'b1;
      r_first    <= 1'b1;
      r_active   <= 1'b0;
      CIn        <= 3'd0;
      seg_out    <= 7'h00;
      an_n       <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      CIn      <= w_cin_nxt;
      r_active <= w_act_nxt;
      if (w_slot_start) begin
        r_restart <= 1'b0;
        if (w_found) begin
          r_first <= 1'b0;
        end
      end
      frame_done <= w_slot_start && w_found && w_wrap;
      an_n       <= w_show ? ~(8'b1 << w_cin_nxt) : 8'hFF;
      seg_out    <= w_show ? seg_in : 7'h00;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: instance a (DIV=8, BLANK=2) covers scanning,
// masking and enable/reset; instance b (DIV=2, BLANK=1) covers the single-digit case.
module tb_seg7_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] mask_a, mask_b;
  logic [6:0] seg_in_a, seg_in_b;
  logic [2:0] cin_a, cin_b;
  logic [6:0] seg_a, seg_b;
  logic [7:0] an_a, an_b;
  logic       fd_a, fd_b;

  int total;
  int bad;

  seg7_scan_ctrl #(.DIV(8), .BLANK(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .dig_mask(mask_a), .seg_in(seg_in_a),
    .CIn(cin_a), .seg_out(seg_a), .an_n(an_a), .frame_done(fd_a)
  );

  seg7_scan_ctrl #(.DIV(2), .BLANK(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .dig_mask(mask_b), .seg_in(seg_in_b),
    .CIn(cin_b), .seg_out(seg_b), .an_n(an_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [2:0] c);
    return 7'h40 | {4'h0, c};
  endfunction

  // upstream mux for instance a: pattern derived from the select
  assign seg_in_a = pat(cin_a);

  // Expected {CIn, an_n, seg_out, frame_done} for instance a at slot position p.
  function automatic logic [18:0] expv(input logic [2:0] c, input int p,
                                      input logic fd, input logic act);
    logic sh;
    sh = act && (p >= 2);
    return {c, sh ? ~(8'b1 << c) : 8'hFF, sh ? pat(c) : 7'h00, fd};
  endfunction

  // Disable one cycle, then re-enable with a new mask; returns on cycle 0 of the scan.
  task automatic restart_a(input logic [7:0] m);
    en_a = 1'b0;
    @(negedge clk);
    mask_a = m;
    en_a   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [18:0] obs;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    mask_a = 8'hFF; mask_b = 8'h80; seg_in_b = 7'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== expv(3'd0, 0, 1'b0, 1'b0)) begin
        bad++; $display("FAIL reset_a got %h want %h", obs, expv(3'd0, 0, 1'b0, 1'b0));
      end
      obs = {cin_b, an_b, seg_b, fd_b};
      total++;
      if (obs !== {3'd0, 8'hFF, 7'h00, 1'b0}) begin
        bad++; $display("FAIL reset_b got %h want %h", obs, {3'd0, 8'hFF, 7'h00, 1'b0});
      end
    end
    en_a  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_scan;
    logic [18:0] obs, ex;
    int s, p;
    for (int k = 0; k < 72; k++) begin
      s = k / 8; p = k % 8;
      ex  = expv(3'(s % 8), p, (p == 0) && (s % 8 == 0), 1'b1);
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL full_scan k=%0d got %h want %h", k, obs, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_masking;
    logic [18:0] obs, ex;
    logic [2:0]  seq3 [3];
    int s, p;
    seq3[0] = 3'd2; seq3[1] = 3'd5; seq3[2] = 3'd7;
    restart_a(8'b1010_0100);
    for (int k = 0; k < 56; k++) begin
      s = k / 8; p = k % 8;
      ex  = expv(seq3[s % 3], p, (p == 0) && (s % 3 == 0), 1'b1);
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL masking k=%0d got %h want %h", k, obs, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_slot_mask;
    logic [18:0] obs, ex;
    int s, p;
    restart_a(8'hFF);
    for (int k = 0; k < 64; k++) begin
      s = k / 8; p = k % 8;
      if (s < 5) ex = expv(3'(s), p, (p == 0) && (s == 0), 1'b1);
      else       ex = expv(3'd0, p, p == 0, 1'b1);
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL mid_slot_mask k=%0d got %h want %h", k, obs, ex);
      end
      if (k == 35) mask_a = 8'h01;
      @(negedge clk);
    end
  endtask

  task automatic test_all_masked;
    logic [18:0] obs, ex;
    int s, p;
    restart_a(8'hFF);
    for (int k = 0; k < 56; k++) begin
      s = k / 8; p = k % 8;
      if (s <= 1)      ex = expv(3'(s), p, (p == 0) && (s == 0), 1'b1);
      else if (s <= 4) ex = expv(3'd1, p, 1'b0, 1'b0);
      else             ex = expv(3'(s - 3), p, 1'b0, 1'b1);
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL all_masked k=%0d got %h want %h", k, obs, ex);
      end
      if (k == 10) mask_a = 8'h00;
      if (k == 36) mask_a = 8'hFF;
      @(negedge clk);
    end
  endtask

  task automatic test_single_digit;
    logic [18:0] obs, ex;
    logic [6:0]  vprev, v;
    vprev = 7'h00;
    mask_b = 8'h80;
    en_b   = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) ex = {3'd7, 8'hFF, 7'h00, 1'b1};
      else            ex = {3'd7, 8'h7F, vprev, 1'b0};
      obs = {cin_b, an_b, seg_b, fd_b};
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL single_digit k=%0d got %h want %h", k, obs, ex);
      end
      v = 7'(k * 13 + 5) | 7'h01;
      seg_in_b = v;
      vprev    = v;
      @(negedge clk);
    end
    en_b = 1'b0;
  endtask

  task automatic test_enable_reset;
    logic [18:0] obs, ex;
    int s, p;
    restart_a(8'hFF);
    for (int k = 0; k <= 44; k++) begin
      s = k / 8; p = k % 8;
      ex  = expv(3'(s), p, (p == 0) && (s == 0), 1'b1);
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL enable_run k=%0d got %h want %h", k, obs, ex);
      end
      if (k == 44) en_a = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== expv(3'd0, 0, 1'b0, 1'b0)) begin
        bad++; $display("FAIL en_low i=%0d got %h want %h", i, obs, expv(3'd0, 0, 1'b0, 1'b0));
      end
      if (i == 1) en_a = 1'b1;
      @(negedge clk);
    end
    for (int p2 = 0; p2 < 4; p2++) begin
      ex  = expv(3'd0, p2, p2 == 0, 1'b1);
      obs = {cin_a, an_a, seg_a, fd_a};
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL en_restart p=%0d got %h want %h", p2, obs, ex);
      end
      if (p2 < 3) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {cin_a, an_a, seg_a, fd_a};
    total++;
    if (obs !== expv(3'd0, 0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL async_reset got %h want %h", obs, expv(3'd0, 0, 1'b0, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_scan();
    test_masking();
    test_mid_slot_mask();
    test_all_masked();
    test_single_digit();
    test_enable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
